// File: rtl/resonator_dds_cmix_round.sv
// Complex-multiply recombination for the resonator DDS: I = rr - ii, Q = ri + ir,
// then round-half-up, saturate and hand off on a valid/ready stream with a saturation counter.

module resonator_dds_cmix_round_lane #(
   parameter int P_W   = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15
) (
   input  logic [P_W:0]     s,
   output logic [OUT_W-1:0] y,
   output logic             sat
);
   localparam logic signed [P_W+1:0] MAXV = (P_W+2)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
   localparam logic signed [P_W+1:0] MINV = ~MAXV;
   localparam logic signed [P_W+1:0] RND  = (P_W+2)'(64'sd1 <<< (SHIFT-1));

   logic signed [P_W+1:0] r;

   always_comb begin
      r = ($signed({s[P_W], s}) + RND) >>> SHIFT;
      if (r > MAXV) begin
         y   = MAXV[OUT_W-1:0];
         sat = 1'b1;
      end else if (r < MINV) begin
         y   = MINV[OUT_W-1:0];
         sat = 1'b1;
      end else begin
         y   = r[OUT_W-1:0];
         sat = 1'b0;
      end
   end
endmodule

module resonator_dds_cmix_round #(
   parameter int P_W   = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [P_W-1:0]   p_rr,
   input  logic [P_W-1:0]   p_ii,
   input  logic [P_W-1:0]   p_ri,
   input  logic [P_W-1:0]   p_ir,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_i,
   output logic [OUT_W-1:0] out_q,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic             sat_flag,
   output logic [CNT_W-1:0] sat_count,
   input  logic             sat_clear
);
   localparam int LANES = 2;  // lane 0 = I, lane 1 = Q

   logic                        adv;
   logic [LANES-1:0][P_W:0]     sum_d;
   logic [LANES-1:0][P_W:0]     s1_sum;
   logic [LANES-1:0][OUT_W-1:0] lane_y;
   logic [LANES-1:0]            lane_sat;
   logic [2:1]                  vld_pipe;
   logic [2:1]                  last_pipe;

   // Whole chain (including upstream multipliers via in_ready) moves only when S2 can drain.
   assign adv       = !vld_pipe[2] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[2];
   assign out_last  = last_pipe[2];

   assign sum_d[0] = {p_rr[P_W-1], p_rr} - {p_ii[P_W-1], p_ii};
   assign sum_d[1] = {p_ri[P_W-1], p_ri} + {p_ir[P_W-1], p_ir};

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         resonator_dds_cmix_round_lane #(
            .P_W  (P_W),
            .OUT_W(OUT_W),
            .SHIFT(SHIFT)
         ) u_lane (
            .s  (s1_sum[g]),
            .y  (lane_y[g]),
            .sat(lane_sat[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_sum    <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
         out_i     <= '0;
         out_q     <= '0;
         sat_flag  <= 1'b0;
      end else if (adv) begin
         s1_sum       <= sum_d;
         vld_pipe[1]  <= in_valid;
         last_pipe[1] <= in_valid & in_last;
         vld_pipe[2]  <= vld_pipe[1];
         last_pipe[2] <= last_pipe[1];
         out_i        <= lane_y[0];
         out_q        <= lane_y[1];
         sat_flag     <= |lane_sat;
      end
   end

   // Clear wins over a simultaneous saturated handshake; count sticks at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sat_count <= '0;
      else if (sat_clear)
         sat_count <= '0;
      else if (vld_pipe[2] && out_ready && sat_flag && !(&sat_count))
         sat_count <= sat_count + 1'b1;
   end
endmodule

// File: tb/tb_resonator_dds_cmix_round.sv
// Directed bench for resonator_dds_cmix_round: a FIFO reference model checked every cycle
// plus literal expectations for latency, rounding, saturation, backpressure, bubbles and reset.

module tb_resonator_dds_cmix_round;
   localparam int P_W = 32, OUT_W = 16, SHIFT = 15, CNT_W = 16;
   localparam longint MAXO = (longint'(1) << (OUT_W-1)) - 1;
   localparam longint MINO = -(longint'(1) << (OUT_W-1));
   localparam longint MAXC = (longint'(1) << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [P_W-1:0]   p_rr = '0, p_ii = '0, p_ri = '0, p_ir = '0;
   logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, sat_clear = 1'b0;
   logic             in_ready, out_valid, out_last, sat_flag;
   logic [OUT_W-1:0] out_i, out_q;
   logic [CNT_W-1:0] sat_count;

   resonator_dds_cmix_round #(.P_W(P_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .sat_flag(sat_flag), .sat_count(sat_count), .sat_clear(sat_clear)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: floor((s + 2^(SHIFT-1)) / 2^SHIFT), clamped to the output range.
   function automatic longint rnd_sat(input longint s, output bit sat);
      longint d, t, r;
      d = longint'(1) << SHIFT;
      t = s + d / 2;
      r = (t >= 0) ? t / d : -((-t + d - 1) / d);
      sat = 1'b1;
      if (r > MAXO) return MAXO;
      if (r < MINO) return MINO;
      sat = 1'b0;
      return r;
   endfunction

   typedef struct {longint i; longint q; bit last; bit sat;} exp_t;
   exp_t   mq[$];
   exp_t   mon_e;
   longint cnt_m = 0;
   bit     prev_stall = 1'b0, hs_sat, s_i, s_q;
   logic [OUT_W-1:0] h_i, h_q;
   logic   h_l;
   bit     bp_rec = 1'b0, bp_done = 1'b0;
   int     bp_got = 0;
   int     bp_q[16];
   bit     bp_l[16];

   always @(negedge clk) begin
      if (reset) begin
         mq.delete();
         cnt_m = 0;
         prev_stall = 1'b0;
      end else begin
         chk("in_ready", in_ready, (!out_valid || out_ready));
         chk("sat_count", sat_count, cnt_m);
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_i", out_i, h_i);
            chk("hold_q", out_q, h_q);
            chk("hold_last", out_last, h_l);
         end
         hs_sat = 1'b0;
         if (out_valid) begin
            if (mq.size() == 0) chk("spurious_beat", 1, 0);
            else begin
               mon_e = mq[0];
               chk("out_i", $signed(out_i), mon_e.i);
               chk("out_q", $signed(out_q), mon_e.q);
               chk("out_last", out_last, mon_e.last);
               chk("sat_flag", sat_flag, mon_e.sat);
               if (out_ready) begin
                  void'(mq.pop_front());
                  hs_sat = mon_e.sat;
                  if (bp_rec && bp_got < 16) begin
                     bp_q[bp_got] = int'($signed(out_q));
                     bp_l[bp_got] = out_last;
                     bp_got++;
                  end
               end
            end
         end
         if (sat_clear) cnt_m = 0;
         else if (hs_sat && cnt_m < MAXC) cnt_m++;
         if (in_valid && in_ready) begin
            mon_e.i = rnd_sat(longint'($signed(p_rr)) - longint'($signed(p_ii)), s_i);
            mon_e.q = rnd_sat(longint'($signed(p_ri)) + longint'($signed(p_ir)), s_q);
            mon_e.sat  = s_i | s_q;
            mon_e.last = in_last;
            mq.push_back(mon_e);
         end
         prev_stall = out_valid && !out_ready;
         h_i = out_i;
         h_q = out_q;
         h_l = out_last;
      end
   end

   task automatic send(input longint rr, input longint ii, input longint ri, input longint ir,
                       input bit last);
      int w = 0;
      bit acc = 1'b0;
      p_rr = 32'(rr); p_ii = 32'(ii); p_ri = 32'(ri); p_ir = 32'(ir);
      in_valid = 1'b1;
      in_last  = last;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         w++;
         if (!acc && w > 200) begin
            chk("send_timeout", 1, 0);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called right after send() with an empty pipe and out_ready high.
   task automatic expect_out(input longint ei, input longint eq, input bit es,
                             input longint ecnt, input string nm);
      int w = 0;
      while (1) begin
         @(negedge clk);
         w++;
         if (out_valid || w > 8) break;
      end
      chk({nm, "_lat"}, w, 2);
      chk({nm, "_i"}, $signed(out_i), ei);
      chk({nm, "_q"}, $signed(out_q), eq);
      chk({nm, "_sat"}, sat_flag, es);
      @(posedge clk);
      #1;
      if (ecnt >= 0) chk({nm, "_cnt"}, sat_count, ecnt);
   endtask

   longint rs[4] = '{16384, 16383, -16384, -16385};
   longint rx[4] = '{1, 0, 0, -1};
   int     pat[4] = '{1, 0, 1, 1};
   int     ov[6];

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_i", out_i, 0);
      chk("rst_q", out_q, 0);
      chk("rst_last", out_last, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_cnt", sat_count, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      send(longint'(1) << 29, 0, 0, 0, 0);
      expect_out(16384, 0, 0, 0, "basic");

      for (int k = 0; k < 4; k++) begin
         send(rs[k], 0, rs[k], 0, 0);
         expect_out(rx[k], rx[k], 0, 0, $sformatf("round%0d", k));
      end

      send(longint'(1) << 30, 0, 0, 0, 0);
      expect_out(32767, 0, 1, 1, "sat_pos");
      send(-(longint'(1) << 30), longint'(1) << 30, 0, 0, 0);
      expect_out(-32768, 0, 1, 2, "sat_neg");
      send(0, 0, longint'(1) << 30, longint'(1) << 30, 0);
      expect_out(0, 32767, 1, 3, "sat_q");
      send(longint'(1) << 30, 0, 0, 0, 0);
      sat_clear = 1'b1;
      expect_out(32767, 0, 1, 0, "sat_clr");
      sat_clear = 1'b0;

      for (int c = 0; c < 6; c++) begin
         in_valid = (c < 4) ? pat[c][0] : 1'b0;
         p_rr = 32'((c + 1) << 15);
         @(negedge clk);
         ov[c] = int'(out_valid);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("bub_ov0", ov[0], 0);
      chk("bub_ov1", ov[1], 0);
      for (int c = 0; c < 4; c++) chk($sformatf("bub_ov%0d", c + 2), ov[c + 2], pat[c]);

      bp_rec = 1'b1;
      bp_got = 0;
      bp_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 8; k++) send(0, 0, longint'(k) << 15, 0, k == 7);
            bp_done = 1'b1;
         end
         begin
            while (!bp_done) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      bp_rec = 1'b0;
      chk("bp_count", bp_got, 8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("bp_q%0d", k), bp_q[k], k);
         chk($sformatf("bp_last%0d", k), bp_l[k], (k == 7) ? 1 : 0);
      end

      send(longint'(1) << 30, 0, 0, 0, 0);
      expect_out(32767, 0, 1, 1, "pre_rst");
      out_ready = 1'b0;
      send(longint'(1) << 29, 0, 0, 0, 0);
      send(longint'(3) << 28, 0, 0, 0, 0);
      chk("stall_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_cnt", sat_count, 0);
      chk("arst_i", out_i, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stale_valid", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(-(longint'(1) << 29), 0, 0, longint'(1) << 29, 0);
      expect_out(-16384, 16384, 0, 0, "post_rst");

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/resonator_dds_cmix_round.md
Name: resonator_dds_cmix_round

Overview:
- Downstream of the 16x16 signed product multipliers in the resonator DDS datapath.
- Takes the four aligned 32-bit partial products of one complex multiply (rr, ii, ri, ir) and forms I = rr - ii and Q = ri + ir.
- Rounds and saturates both results to OUT_W bits and emits them on a valid/ready stream.
- in_ready drives the upstream multipliers' ce, so the whole multiply chain stalls together.

Parameters:
- P_W, 32, width of each input product (signed)
- OUT_W, 16, output I/Q width (signed)
- SHIFT, 15, right shift applied after summation; round-half-up at bit SHIFT-1
- CNT_W, 16, saturation counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- p_rr  in  P_W  signed product re*re
- p_ii  in  P_W  signed product im*im
- p_ri  in  P_W  signed product re*im
- p_ir  in  P_W  signed product im*re
- in_valid  in  1  products valid this cycle
- in_last  in  1  frame tag, passed through aligned with data
- in_ready  out  1  accept/advance; also ce for upstream multipliers
- out_i  out  OUT_W  rounded, saturated I
- out_q  out  OUT_W  rounded, saturated Q
- out_valid  out  1  output beat valid
- out_last  out  1  tag aligned with out_i/out_q
- out_ready  in  1  downstream accepts beat
- sat_flag  out  1  current output beat saturated on I or Q
- sat_count  out  CNT_W  count of saturated beats accepted downstream, sticky at max
- sat_clear  in  1  synchronous clear of sat_count

Behaviour:
- Reset (async, active-high): all valid bits = 0, out_valid = 0, out_i = out_q = 0, out_last = 0, sat_flag = 0, sat_count = 0. Reset mid-stream drops in-flight beats; no partial beat is emitted after release.
- Two register stages: S1 (sum), S2 (round/sat, output register). Each stage carries a valid bit and a last bit.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready).
- When adv = 1, S1 <= inputs with valid = in_valid, and S2 <= S1. When adv = 0, all stages hold. Bubbles propagate as valid = 0.
- A beat is accepted when in_valid && in_ready. It appears on the outputs exactly 2 cycles later if out_ready is held high.
- S1 arithmetic, P_W+1 bits, sign-extended: sI = p_rr - p_ii; sQ = p_ri + p_ir.
- S2 arithmetic, P_W+2 bits: r = (s + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift). If r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1. If r < -2^(OUT_W-1), output -2^(OUT_W-1). Otherwise output r[OUT_W-1:0].
- sat_flag = OR of I and Q saturation for the beat in S2; meaningful only with out_valid.
- Output data is stable while out_valid && !out_ready.
- sat_count increments by 1 on each cycle with out_valid && out_ready && sat_flag and holds at 2^CNT_W-1. sat_clear has priority over increment: on a simultaneous event the result is 0.
- Throughput is 1 beat/cycle with out_ready held high.

Test Plan:
- Latency/basic: out_ready = 1; p_rr = 2^29, others 0, in_valid pulse at cycle 0 -> out_valid at cycle 2 with out_i = 16384, out_q = 0, sat_flag = 0.
- Rounding: I sums of 16384, 16383, -16384, -16385 (via p_rr) -> out_i = 1, 0, 0, -1 respectively.
- Saturation and counter: p_rr = 2^30, p_ii = 0 -> out_i = 32767, sat_flag = 1, sat_count = 1. p_rr = -2^30, p_ii = 2^30 -> out_i = -32768, sat_count = 2. Then sat_clear together with a saturated accepted beat -> sat_count = 0.
- Backpressure: stream 8 beats (ri = k*2^15, ir = 0 -> out_q = k) with out_ready toggled pseudo-randomly -> all 8 emitted in order, q = 0..7, no drops or duplicates. in_ready = 0 whenever out_valid && !out_ready. Output held stable while stalled. in_last on beat 7 -> out_last only on q = 7.
- Bubbles: in_valid pattern 1,0,1,1 with out_ready = 1 -> out_valid pattern 1,0,1,1 delayed by 2 cycles.
- Reset mid-operation: assert reset with 2 beats in flight and out_ready = 0 -> out_valid = 0 immediately (async), sat_count = 0. After release, the first new beat appears at latency 2 with no stale data.
